vga_timing_decoder: RTL and testbench
=====================================

VGA_TIMING_DECODER -- requirements
Module: vga_timing_decoder

Interface
REQ-001 SHALL have parameter LOCK_FRAMES, default 2, the number of consecutive good frames required to assert lock.
REQ-002 SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have port pix_en, input, 1, one-clk pixel strobe; all sampling and counting are qualified by it.
REQ-005 SHALL have port hsync_in, input, 1, active-low horizontal sync, synchronous to clk.
REQ-006 SHALL have port vsync_in, input, 1, active-low vertical sync, synchronous to clk.
REQ-007 SHALL have port locked, output, 1, high while timing matches 640x480 (800x521 total).
REQ-008 SHALL have port x, output, 10, recovered active column 0..639; 0 outside the active area.
REQ-009 SHALL have port y, output, 10, recovered active row 0..479; 0 outside the active area.
REQ-010 SHALL have port display_on, output, 1, high for an active pixel while locked.
REQ-011 SHALL have port line_err, output, 1, one-clk pulse on a bad line length or a missing hsync.
REQ-012 SHALL have port frame_err, output, 1, one-clk pulse on a bad frame length.

Function
REQ-013 SHALL register hsync_in and vsync_in on pix_en cycles; a line start (LS) is the pix_en cycle where sampled hsync goes 1->0.
REQ-014 SHALL keep col_cnt[10:0]: LS sets it to 0; otherwise it increments on pix_en and saturates at 2047.
REQ-015 SHALL keep row_cnt[9:0]: a frame start (FS), an LS with vsync_in=0 and the previous-LS vsync=1, sets it to 0; any other LS increments it.
REQ-016 SHALL check, at each LS, that the completed line had col_cnt==799; otherwise it raises a line-length fault.
REQ-017 SHALL raise a line-length fault when col_cnt reaches 1023 without an LS (missing hsync), once per occurrence.
REQ-018 SHALL check, at each FS, that the completed frame had row_cnt==520; otherwise it raises a frame-length fault.
REQ-019 SHALL implement FSM states SEARCH, VERIFY and LOCKED.
REQ-020 SHALL transition SEARCH->VERIFY at the first FS, clearing good_cnt.
REQ-021 SHALL, in VERIFY at each FS, increment good_cnt if the frame had no fault; on reaching LOCK_FRAMES it goes to LOCKED.
REQ-022 SHALL, in VERIFY, return to SEARCH on any fault, without pulsing an error.
REQ-023 SHALL, in LOCKED, pulse line_err or frame_err for 1 clk on the matching fault, go to SEARCH and deassert locked the next clk.
REQ-024 SHALL pulse both line_err and frame_err in the same clk when both faults are detected together.
REQ-025 SHALL treat the active area as col 144..783 and row 31..510, with x=col_cnt-144 and y=row_cnt-31 (10-bit truncation).
REQ-026 SHALL register x, y and display_on, giving one clk of latency from the pix_en that updates the counters.
REQ-027 SHALL hold display_on=0, x=0 and y=0 whenever not LOCKED.
REQ-028 SHALL make locked=1 exactly when the state is LOCKED.

Reset
REQ-029 SHALL, on reset, set state=SEARCH, col_cnt=0, row_cnt=0, good_cnt=0 and the sampled syncs=1.
REQ-030 SHALL, on reset, drive all outputs to 0.
REQ-031 SHALL abandon any partial frame when reset is asserted mid-frame; after release, lock needs a fresh FS plus LOCK_FRAMES good frames.

Structure
REQ-032 SHALL take the timing constants (H_TOTAL=800, H_PULSE=96, H_BP=48, H_ACTIVE=640, V_TOTAL=521, V_PULSE=2, V_BP=29, V_ACTIVE=480) and the FSM state encoding from shared package vga_timing_pkg.
REQ-033 SHALL instantiate the sub-module vga_sync_edge once per sync input (pix_en-qualified falling-edge detector).

Verification
REQ-034 SHALL verify nominal lock: clean 800x521 timing, LOCK_FRAMES=2 -> locked rises at the 3rd FS, then the first active pixel gives x=0, y=0, display_on=1.
REQ-035 SHALL verify a short line: while locked, one line of 798 pixels -> line_err one-clk pulse at that LS, locked=0 next clk, display_on=0.
REQ-036 SHALL verify a bad frame: while locked, a frame of 520 lines -> frame_err pulse; re-lock after 2 further good frames.
REQ-037 SHALL verify missing hsync: hsync held high while locked -> line_err pulse when col_cnt=1023, state SEARCH.
REQ-038 SHALL verify mid-frame reset: reset at row 200 -> outputs 0 immediately; locked rises only at the 3rd FS after release.
REQ-039 SHALL verify pix_en gating: pix_en every 2nd clk -> same lock and x/y results as REQ-034, counters frozen on non-strobe clks.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480 timing constants and lock FSM encoding
package vga_timing_pkg;

    localparam int H_TOTAL  = 800;
    localparam int H_PULSE  = 96;
    localparam int H_BP     = 48;
    localparam int H_ACTIVE = 640;
    localparam int V_TOTAL  = 521;
    localparam int V_PULSE  = 2;
    localparam int V_BP     = 29;
    localparam int V_ACTIVE = 480;

    // Counter values used by the decoder, sized to match the counters
    localparam logic [10:0] H_LAST      = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT_FIRST = 11'(H_PULSE + H_BP);
    localparam logic [10:0] H_ACT_END   = 11'(H_PULSE + H_BP + H_ACTIVE);
    localparam logic [9:0]  V_ACT_FIRST = 10'(V_PULSE + V_BP);
    localparam logic [9:0]  V_ACT_END   = 10'(V_PULSE + V_BP + V_ACTIVE);
    localparam logic [10:0] H_NO_SYNC   = 11'd1023;
    localparam logic [10:0] COL_MAX     = 11'd2047;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } lock_state_e;

endpackage

// File: rtl/vga_sync_edge.sv
// rtl/vga_sync_edge.sv - pix_en-qualified falling-edge detector for one sync input
module vga_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic pix_en,
    input  logic sync_in,
    output logic fall
);

    logic sync_q;
    logic sync_d;

    // Hold the last strobed level between pixel strobes
    always_comb begin
        sync_d = pix_en ? sync_in : sync_q;
    end

    // Sampled level idles high so a low input right after reset reads as an edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign fall = pix_en & sync_q & ~sync_in;

endmodule

// File: rtl/vga_timing_decoder.sv
// rtl/vga_timing_decoder.sv - recovers 640x480 position and lock from raw hsync/vsync
module vga_timing_decoder #(
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic       locked,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       display_on,
    output logic       line_err,
    output logic       frame_err
);
    import vga_timing_pkg::*;

    localparam int GW = $clog2(LOCK_FRAMES + 1);

    lock_state_e state_q, state_d;
    logic [10:0] col_cnt_q, col_cnt_d;
    logic [9:0]  row_cnt_q, row_cnt_d;
    logic        vs_ls_q, vs_ls_d;
    logic [GW-1:0] good_cnt_q, good_cnt_d, good_inc;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic        display_on_q, display_on_d;
    logic        line_err_q, line_err_d, frame_err_q, frame_err_d;
    logic        ls, fs, vs_fall, unused_vs_fall;
    logic        line_fault, frame_fault, active;

    vga_sync_edge u_hsync_edge (
        .clk     (clk),
        .reset   (reset),
        .pix_en  (pix_en),
        .sync_in (hsync_in),
        .fall    (ls)
    );

    vga_sync_edge u_vsync_edge (
        .clk     (clk),
        .reset   (reset),
        .pix_en  (pix_en),
        .sync_in (vsync_in),
        .fall    (vs_fall)
    );

    // Frame start is judged at line-start time from the vsync level, not its edge
    assign unused_vs_fall = vs_fall;
    assign fs             = ls & ~vsync_in & vs_ls_q;
    assign good_inc       = good_cnt_q + GW'(1);

    // Position counters and line/frame length checks
    always_comb begin
        col_cnt_d   = col_cnt_q;
        row_cnt_d   = row_cnt_q;
        vs_ls_d     = vs_ls_q;
        line_fault  = 1'b0;
        frame_fault = 1'b0;
        if (ls) begin
            col_cnt_d  = '0;
            vs_ls_d    = vsync_in;
            line_fault = (col_cnt_q != H_LAST);
            if (fs) begin
                row_cnt_d   = '0;
                frame_fault = (row_cnt_q != V_LAST);
            end else begin
                row_cnt_d = row_cnt_q + 10'd1;
            end
        end else if (pix_en) begin
            if (col_cnt_q != COL_MAX) begin
                col_cnt_d = col_cnt_q + 11'd1;
            end
            // Fires only on the step into 1023, so a stuck hsync reports once
            line_fault = (col_cnt_q == H_NO_SYNC - 11'd1);
        end
    end

    // Lock FSM: faults while verifying restart silently, faults while locked are reported
    always_comb begin
        state_d     = state_q;
        good_cnt_d  = good_cnt_q;
        line_err_d  = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            ST_SEARCH: begin
                if (fs) begin
                    state_d    = ST_VERIFY;
                    good_cnt_d = '0;
                end
            end
            ST_VERIFY: begin
                if (line_fault || frame_fault) begin
                    state_d = ST_SEARCH;
                end else if (fs) begin
                    good_cnt_d = good_inc;
                    if (good_inc == GW'(LOCK_FRAMES)) begin
                        state_d = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if (line_fault || frame_fault) begin
                    line_err_d  = line_fault;
                    frame_err_d = frame_fault;
                    state_d     = ST_SEARCH;
                end
            end
            default: begin
                state_d = ST_SEARCH;
            end
        endcase
    end

    // Active-area position, gated by the state being entered so it never outlives lock
    always_comb begin
        active = (col_cnt_q >= H_ACT_FIRST) && (col_cnt_q < H_ACT_END) &&
                 (row_cnt_q >= V_ACT_FIRST) && (row_cnt_q < V_ACT_END);
        display_on_d = active && (state_d == ST_LOCKED);
        x_d = display_on_d ? 10'(col_cnt_q - H_ACT_FIRST) : 10'd0;
        y_d = display_on_d ? (row_cnt_q - V_ACT_FIRST) : 10'd0;
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_SEARCH;
            col_cnt_q    <= '0;
            row_cnt_q    <= '0;
            vs_ls_q      <= 1'b1;
            good_cnt_q   <= '0;
            x_q          <= '0;
            y_q          <= '0;
            display_on_q <= 1'b0;
            line_err_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_cnt_q    <= col_cnt_d;
            row_cnt_q    <= row_cnt_d;
            vs_ls_q      <= vs_ls_d;
            good_cnt_q   <= good_cnt_d;
            x_q          <= x_d;
            y_q          <= y_d;
            display_on_q <= display_on_d;
            line_err_q   <= line_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign locked     = (state_q == ST_LOCKED);
    assign x          = x_q;
    assign y          = y_q;
    assign display_on = display_on_q;
    assign line_err   = line_err_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_vga_timing_decoder.sv
// tb/tb_vga_timing_decoder.sv - directed self-checking bench for vga_timing_decoder
module tb_vga_timing_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       pix_en;
    logic       hsync_in;
    logic       vsync_in;
    logic       locked;
    logic [9:0] x;
    logic [9:0] y;
    logic       display_on;
    logic       line_err;
    logic       frame_err;

    int n_pass  = 0;
    int n_total = 0;

    // Source timing model: current position and the lengths of the current line/frame
    int cur_h      = 0;
    int cur_v      = 0;
    int line_len   = 800;
    int frame_rows = 521;
    bit div2       = 1'b0;

    typedef struct {
        int row;
        int col;
        int ex;
        int ey;
        int edisp;
    } probe_t;

    probe_t probes[9];

    always #5 clk = ~clk;

    vga_timing_decoder #(.LOCK_FRAMES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .pix_en     (pix_en),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .locked     (locked),
        .x          (x),
        .y          (y),
        .display_on (display_on),
        .line_err   (line_err),
        .frame_err  (frame_err)
    );

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pix_en = 1'b0;
        tick();
    endtask

    // One pixel strobe; in divided mode a non-strobe clock precedes it
    task automatic drive_raw(input logic hs, input logic vs);
        if (div2) idle();
        hsync_in = hs;
        vsync_in = vs;
        pix_en   = 1'b1;
        tick();
        pix_en   = 1'b0;
    endtask

    task automatic drive_pixel();
        drive_raw(cur_h >= 96, cur_v >= 2);
        cur_h++;
        if (cur_h >= line_len) begin
            cur_h    = 0;
            line_len = 800;
            cur_v++;
            if (cur_v >= frame_rows) begin
                cur_v      = 0;
                frame_rows = 521;
            end
        end
    endtask

    task automatic run_to(input int r, input int c);
        while (!(cur_v == r && cur_h == c)) drive_pixel();
    endtask

    // Drive each probe pixel, then two idle clocks: outputs must reflect that pixel
    task automatic run_probes(input string tag);
        for (int i = 0; i < 9; i++) begin
            run_to(probes[i].row, probes[i].col);
            drive_pixel();
            idle();
            idle();
            check($sformatf("%s probe%0d x", tag, i), x, probes[i].ex);
            check($sformatf("%s probe%0d y", tag, i), y, probes[i].ey);
            check($sformatf("%s probe%0d display_on", tag, i), display_on, probes[i].edisp);
            check($sformatf("%s probe%0d locked", tag, i), locked, 1);
        end
    endtask

    initial begin
        #100_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        probes = '{
            '{30, 144, 0, 0, 0},
            '{31, 143, 0, 0, 0},
            '{31, 144, 0, 0, 1},
            '{31, 783, 639, 0, 1},
            '{31, 784, 0, 0, 0},
            '{100, 400, 256, 69, 1},
            '{510, 144, 0, 479, 1},
            '{510, 783, 639, 479, 1},
            '{511, 144, 0, 0, 0}
        };

        reset    = 1'b1;
        pix_en   = 1'b0;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        repeat (3) tick();
        check("reset locked", locked, 0);
        check("reset x", x, 0);
        check("reset y", y, 0);
        check("reset display_on", display_on, 0);
        check("reset line_err", line_err, 0);
        check("reset frame_err", frame_err, 0);
        reset = 1'b0;
        tick();

        // Nominal lock: third frame start
        drive_pixel();
        check("fs1 locked", locked, 0);
        run_to(0, 0);
        drive_pixel();
        check("fs2 locked", locked, 0);
        run_to(0, 0);
        check("pre fs3 locked", locked, 0);
        drive_pixel();
        check("fs3 locked", locked, 1);
        run_probes("full");

        // Short line of 798 pixels while locked
        run_to(515, 0);
        line_len = 798;
        run_to(516, 0);
        check("short pre line_err", line_err, 0);
        check("short pre locked", locked, 1);
        drive_pixel();
        check("short line_err", line_err, 1);
        check("short frame_err", frame_err, 0);
        check("short locked", locked, 0);
        check("short display_on", display_on, 0);
        idle();
        check("short line_err width", line_err, 0);

        // Relock, then a 520-line frame
        run_to(0, 0);
        drive_pixel();
        run_to(0, 0);
        drive_pixel();
        run_to(0, 0);
        drive_pixel();
        check("relock after short", locked, 1);
        frame_rows = 520;
        run_to(0, 0);
        check("badframe pre frame_err", frame_err, 0);
        drive_pixel();
        check("badframe frame_err", frame_err, 1);
        check("badframe line_err", line_err, 0);
        check("badframe locked", locked, 0);
        idle();
        check("badframe frame_err width", frame_err, 0);
        run_to(0, 0);
        drive_pixel();
        check("badframe fs+1 locked", locked, 0);
        run_to(0, 0);
        drive_pixel();
        check("badframe fs+2 locked", locked, 0);
        run_to(0, 0);
        drive_pixel();
        check("badframe relock", locked, 1);

        // Mid-frame reset at row 200, then continue with pix_en every 2nd clk
        run_to(200, 300);
        drive_pixel();
        idle();
        check("prereset display_on", display_on, 1);
        check("prereset x", x, 156);
        check("prereset y", y, 169);
        reset = 1'b1;
        #1;
        check("midreset locked", locked, 0);
        check("midreset display_on", display_on, 0);
        check("midreset x", x, 0);
        check("midreset y", y, 0);
        repeat (3) tick();
        reset = 1'b0;
        div2  = 1'b1;
        run_to(0, 0);
        check("postreset partial locked", locked, 0);
        drive_pixel();
        check("postreset fs1 locked", locked, 0);
        run_to(0, 0);
        drive_pixel();
        check("postreset fs2 locked", locked, 0);
        run_to(0, 0);
        check("postreset pre fs3 locked", locked, 0);
        drive_pixel();
        check("postreset fs3 locked", locked, 1);
        run_probes("half");

        // Missing hsync while locked: fault when col_cnt reaches 1023
        run_to(512, 0);
        drive_pixel();
        repeat (1022) drive_raw(1'b1, 1'b1);
        check("nohsync pre line_err", line_err, 0);
        check("nohsync pre locked", locked, 1);
        drive_raw(1'b1, 1'b1);
        check("nohsync line_err", line_err, 1);
        check("nohsync frame_err", frame_err, 0);
        check("nohsync locked", locked, 0);
        drive_raw(1'b1, 1'b1);
        check("nohsync line_err once", line_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
